// File: rtl/rv32i_types_pkg.sv
// Shared types for the data-bus arbiter: FSM states and requester indices.
package rv32i_types_pkg;

  localparam int unsigned DBUS_NREQ = 2;
  localparam int unsigned BYTE_EN_W = 4;

  // Requester indices on the shared data bus
  localparam logic REQ_PIPE  = 1'b0;
  localparam logic REQ_RMGMT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } dbus_arb_state_t;

endpackage

// File: rtl/dbus_arbiter_if.sv
// Data-bus bundle between two requesters, the arbiter and memory.
// master: arbiter view (drives memory side, returns busy/rdata to requesters).
// slave:  environment view (requesters and memory).
interface dbus_arbiter_if #(
  parameter int unsigned WORD_W = 32
);
  import rv32i_types_pkg::*;

  logic [DBUS_NREQ-1:0][WORD_W-1:0]    m_addr;
  logic [DBUS_NREQ-1:0][WORD_W-1:0]    m_wdata;
  logic [DBUS_NREQ-1:0]                m_ren;
  logic [DBUS_NREQ-1:0]                m_wen;
  logic [DBUS_NREQ-1:0][BYTE_EN_W-1:0] m_byte_en;
  logic [WORD_W-1:0]                   m_rdata;
  logic [DBUS_NREQ-1:0]                m_busy;

  logic [WORD_W-1:0]                   s_addr;
  logic [WORD_W-1:0]                   s_wdata;
  logic                                s_ren;
  logic                                s_wen;
  logic [BYTE_EN_W-1:0]                s_byte_en;
  logic [WORD_W-1:0]                   s_rdata;
  logic                                s_busy;

  modport master (
    input  m_addr, m_wdata, m_ren, m_wen, m_byte_en, s_rdata, s_busy,
    output m_rdata, m_busy, s_addr, s_wdata, s_ren, s_wen, s_byte_en
  );

  modport slave (
    output m_addr, m_wdata, m_ren, m_wen, m_byte_en, s_rdata, s_busy,
    input  m_rdata, m_busy, s_addr, s_wdata, s_ren, s_wen, s_byte_en
  );

endinterface

// File: rtl/dbus_arb_select.sv
// Tie-break between the two data-bus requesters.
// DBUS_ARB_RR_EN defined:   round-robin, the requester not granted last wins a tie.
// DBUS_ARB_RR_EN undefined: fixed priority, RISC-MGMT (requester 1) wins a tie.
module dbus_arb_select
  import rv32i_types_pkg::*;
(
  input  logic [DBUS_NREQ-1:0] req,
  input  logic                 last_grant,
  output logic                 winner
);

`ifdef DBUS_ARB_RR_EN
  // Single requester wins outright; on a tie hand the bus to the other side
  always_comb begin
    winner = REQ_PIPE;
    if (&req) begin
      winner = ~last_grant;
    end else if (req[REQ_RMGMT]) begin
      winner = REQ_RMGMT;
    end
  end
`else
  // Last grant is still tracked by the caller but plays no part in selection
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  // RISC-MGMT wins whenever it asks
  always_comb begin
    winner = REQ_PIPE;
    if (req[REQ_RMGMT]) begin
      winner = REQ_RMGMT;
    end
  end
`endif

endmodule

// File: rtl/dbus_arbiter.sv
// Two-requester data-bus arbiter (pipeline port 0, RISC-MGMT port 1).
// Grant is combinational in IDLE and held in LOCKn until memory completes
// or the owner drops its request. Tie-break policy selected by
// DBUS_ARB_RR_EN inside dbus_arb_select.
module dbus_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic           CLK,
  input  logic           nRST,
  dbus_arbiter_if.master bus
);

  dbus_arb_state_t       r_state;
  dbus_arb_state_t       w_state_next;
  logic                  r_last_grant;
  logic                  w_last_grant_next;

  logic [DBUS_NREQ-1:0]  w_req;
  logic                  w_winner;
  logic                  w_gnt_valid;
  logic                  w_gnt_idx;

  logic [WORD_W-1:0]     w_s_addr;
  logic [WORD_W-1:0]     w_s_wdata;
  logic                  w_s_ren;
  logic                  w_s_wen;
  logic [BYTE_EN_W-1:0]  w_s_byte_en;
  logic [DBUS_NREQ-1:0]  w_m_busy;

  assign w_req = bus.m_ren | bus.m_wen;

  dbus_arb_select u_select (
    .req        (w_req),
    .last_grant (r_last_grant),
    .winner     (w_winner)
  );

  // State and last-grant registers; requester 0 wins the first tie after reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_RMGMT;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  // Grant selection, next state and the muxed bus fields
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_gnt_valid       = 1'b0;
    w_gnt_idx         = REQ_PIPE;
    w_s_addr          = '0;
    w_s_wdata         = '0;
    w_s_ren           = 1'b0;
    w_s_wen           = 1'b0;
    w_s_byte_en       = '0;
    w_m_busy          = '1;

    unique case (r_state)
      IDLE: begin
        w_gnt_valid = |w_req;
        w_gnt_idx   = w_winner;
      end
      LOCK0: begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = REQ_PIPE;
      end
      LOCK1: begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = REQ_RMGMT;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_gnt_valid) begin
      w_s_addr            = bus.m_addr[w_gnt_idx];
      w_s_wdata           = bus.m_wdata[w_gnt_idx];
      w_s_ren             = bus.m_ren[w_gnt_idx];
      w_s_wen             = bus.m_wen[w_gnt_idx];
      w_s_byte_en         = bus.m_byte_en[w_gnt_idx];
      w_m_busy[w_gnt_idx] = bus.s_busy;

      // Abort releases the bus without touching the fairness record
      if (!w_req[w_gnt_idx]) begin
        w_state_next = IDLE;
      end else if (!bus.s_busy) begin
        w_state_next      = IDLE;
        w_last_grant_next = w_gnt_idx;
      end else begin
        w_state_next = w_gnt_idx ? LOCK1 : LOCK0;
      end
    end
  end

  assign bus.s_addr    = w_s_addr;
  assign bus.s_wdata   = w_s_wdata;
  assign bus.s_ren     = w_s_ren;
  assign bus.s_wen     = w_s_wen;
  assign bus.s_byte_en = w_s_byte_en;
  assign bus.m_busy    = w_m_busy;
  assign bus.m_rdata   = bus.s_rdata;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of bus ownership.
module tb_dbus_arbiter;

  localparam int unsigned W = 32;

  logic CLK;
  logic nRST;

  dbus_arbiter_if #(.WORD_W(W)) bus ();

  dbus_arbiter #(.WORD_W(W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Model: owner of an in-flight transfer (-1 = bus free) and last completer
  int owner = -1;
  int last  = 1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b00) return -1;
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef DBUS_ARB_RR_EN
    return 1 - last;
`else
    return 1;
`endif
  endfunction

  function automatic int granted();
    logic [1:0] r;
    r = bus.m_ren | bus.m_wen;
    return (owner >= 0) ? owner : pick(r);
  endfunction

  task automatic check_now(input string tag);
    int              g;
    logic [W-1:0]    ea;
    logic [W-1:0]    ed;
    logic            er;
    logic            ew;
    logic [3:0]      eb;
    logic [1:0]      ebusy;
    g     = granted();
    ea    = '0;
    ed    = '0;
    er    = 1'b0;
    ew    = 1'b0;
    eb    = '0;
    ebusy = 2'b11;
    if (g >= 0) begin
      ea       = bus.m_addr[g];
      ed       = bus.m_wdata[g];
      er       = bus.m_ren[g];
      ew       = bus.m_wen[g];
      eb       = bus.m_byte_en[g];
      ebusy[g] = bus.s_busy;
    end
    check_val({tag, ":s_addr"},    64'(bus.s_addr),    64'(ea));
    check_val({tag, ":s_wdata"},   64'(bus.s_wdata),   64'(ed));
    check_val({tag, ":s_ren"},     64'(bus.s_ren),     64'(er));
    check_val({tag, ":s_wen"},     64'(bus.s_wen),     64'(ew));
    check_val({tag, ":s_byte_en"}, 64'(bus.s_byte_en), 64'(eb));
    check_val({tag, ":m_busy"},    64'(bus.m_busy),    64'(ebusy));
    check_val({tag, ":m_rdata"},   64'(bus.m_rdata),   64'(bus.s_rdata));
  endtask

  // Advance the ownership model across one rising edge
  task automatic model_step();
    int         g;
    logic [1:0] r;
    r = bus.m_ren | bus.m_wen;
    g = granted();
    if (!nRST) begin
      owner = -1;
      last  = 1;
    end else if (g >= 0) begin
      if (!r[g]) begin
        owner = -1;
      end else if (!bus.s_busy) begin
        owner = -1;
        last  = g;
      end else begin
        owner = g;
      end
    end
  endtask

  task automatic drive(input logic [1:0] ren, input logic [1:0] wen, input logic busy);
    bus.m_ren  = ren;
    bus.m_wen  = wen;
    bus.s_busy = busy;
    for (int i = 0; i < 2; i++) begin
      bus.m_addr[i]    = $urandom;
      bus.m_wdata[i]   = $urandom;
      bus.m_byte_en[i] = 4'($urandom);
    end
    bus.s_rdata = $urandom;
  endtask

  // Inputs are set just after a falling edge; check mid-cycle, then clock
  task automatic cyc(input string tag);
    #2;
    check_now(tag);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  initial begin
    logic [1:0] ren;
    logic [1:0] wen;

    nRST = 1'b0;
    drive(2'b00, 2'b00, 1'b0);
    #3;
    check_now("reset");
    check_val("reset:m_busy_const", 64'(bus.m_busy), 64'h3);
    @(negedge CLK);
    nRST = 1'b1;

    // Single pipeline read at 0x100, memory busy for three cycles
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 2'b00, k < 3);
      bus.m_addr[0] = 32'h100;
      cyc("single");
    end
    drive(2'b00, 2'b00, 1'b0);
    cyc("idle");

    // Sustained contention: two-cycle transfers back to back
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, 2'b00, (k % 2) == 0);
      cyc("contend");
    end
    drive(2'b11, 2'b11, 1'b0);
    cyc("contend_rw");
    drive(2'b01, 2'b00, 1'b0);
    cyc("drop1");
    drive(2'b00, 2'b00, 1'b0);
    cyc("idle2");

    // Requester 1 arrives while 0 holds the bus
    drive(2'b01, 2'b00, 1'b1);
    cyc("lock0");
    drive(2'b11, 2'b00, 1'b1);
    cyc("lock0_hold");
    drive(2'b11, 2'b00, 1'b0);
    cyc("lock0_done");
    drive(2'b10, 2'b00, 1'b0);
    cyc("switch1");

    // Abort out of LOCK0
    drive(2'b01, 2'b00, 1'b1);
    cyc("abort_a");
    drive(2'b00, 2'b00, 1'b1);
    cyc("abort_b");

    // Read and write together from one requester
    drive(2'b01, 2'b01, 1'b0);
    cyc("rw_pass");

    // Reset in the middle of a LOCK1 transfer
    drive(2'b10, 2'b00, 1'b1);
    cyc("lock1");
    drive(2'b11, 2'b00, 1'b1);
    #1;
    nRST = 1'b0;
    #1;
    owner = -1;
    last  = 1;
    check_now("arst");
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    nRST = 1'b1;
    drive(2'b11, 2'b00, 1'b0);
    cyc("post_rst");
    drive(2'b11, 2'b00, 1'b0);
    cyc("post_rst2");

    // Random traffic with sticky requests
    ren = 2'b00;
    wen = 2'b00;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) ren = 2'($urandom);
      if ($urandom_range(0, 3) == 0) wen = 2'($urandom);
      drive(ren, wen, $urandom_range(0, 2) != 0);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, bus data/address width.
REQ-002 SHALL have input CLK, width 1: clock, rising-edge active.
REQ-003 SHALL have input nRST, width 1: reset, asynchronous, active-low.
REQ-004 SHALL have input m_addr, width 2xWORD_W: requester addresses; index 0 = pipeline data port, index 1 = RISC-MGMT extension port.
REQ-005 SHALL have input m_wdata, width 2xWORD_W: requester store data.
REQ-006 SHALL have input m_ren, width 2: read requests.
REQ-007 SHALL have input m_wen, width 2: write requests.
REQ-008 SHALL have input m_byte_en, width 2x4: requester byte enables.
REQ-009 SHALL have output m_rdata, width WORD_W: load data, broadcast to both requesters.
REQ-010 SHALL have output m_busy, width 2: per-requester busy; low marks completion.
REQ-011 SHALL have output s_addr, width WORD_W: granted address toward memory.
REQ-012 SHALL have outputs s_wdata (WORD_W), s_ren (1), s_wen (1), s_byte_en (4): granted request fields toward memory.
REQ-013 SHALL have input s_rdata, width WORD_W: memory load data.
REQ-014 SHALL have input s_busy, width 1: memory busy; low = transfer complete this cycle.

Function
REQ-015 SHALL define req[i] = m_ren[i] | m_wen[i].
REQ-016 SHALL implement FSM states IDLE, LOCK0, LOCK1.
REQ-017 IDLE: winner's fields SHALL drive s_* combinationally in the same cycle (zero added latency); no request -> s_ren=s_wen=0, s_addr/s_wdata/s_byte_en=0.
REQ-018 IDLE, winner n, s_busy=1 -> next state LOCKn; s_busy=0 (single-cycle completion) -> remain IDLE, transfer counted complete.
REQ-019 LOCKn: s_* SHALL follow requester n live; other requester's request SHALL be ignored.
REQ-020 LOCKn -> IDLE on the cycle s_busy=0 (completion) or req[n]=0 (requester abort); arbiter does not re-issue aborted transfers.
REQ-021 m_busy[n] SHALL equal s_busy while n is granted (IDLE winner or LOCKn); otherwise m_busy[n]=1.
REQ-022 m_rdata SHALL equal s_rdata unconditionally.
REQ-023 Single requester active -> that requester wins.
REQ-024 Both active in IDLE -> winner per arbitration policy (REQ-029/030).
REQ-025 Last-grant register SHALL update to n on every completed transfer of requester n; aborts SHALL not update it.
REQ-026 Back-to-back: a requester holding req after completion SHALL be re-arbitrated in IDLE the next cycle; no idle bubble beyond one arbitration cycle.
REQ-027 A write and read asserted together by one requester SHALL pass through unchanged (memory side defines behaviour).

Reset
REQ-028 nRST low SHALL asynchronously force state IDLE and last-grant=1 (requester 0 wins first tie); outputs then follow REQ-017/021 combinationally: with no requests s_ren=s_wen=0, m_busy=2'b11.

Configuration
REQ-029 With DBUS_ARB_RR_EN defined: round-robin tie-break; winner = requester other than last-grant.
REQ-030 Without DBUS_ARB_RR_EN: fixed priority, requester 1 (RISC-MGMT) always wins ties; last-grant register still present but unused for selection.

Structure
REQ-031 State enum dbus_arb_state_t {IDLE, LOCK0, LOCK1} and requester index constants REQ_PIPE=0, REQ_RMGMT=1 SHALL live in rv32i_types_pkg.
REQ-032 Tie-break logic SHALL be one sub-module, dbus_arb_select (inputs req, last_grant; output winner), with the macro confined to it.

Verification
REQ-033 Reset, no requests -> s_ren=s_wen=0, m_busy=2'b11, state IDLE.
REQ-034 m_ren[0]=1, addr 0x100, s_busy low after 3 cycles -> s_addr=0x100 from cycle 0, m_busy[0] low exactly on completion cycle, m_busy[1]=1 throughout.
REQ-035 Both request simultaneously after reset, RR enabled -> req 0 served first, req 1 next; repeated contention alternates 0,1,0,1.
REQ-036 Same stimulus, RR disabled -> req 1 always served first; req 0 served only after req 1 drops.
REQ-037 req 1 arrives while LOCK0 -> s_addr stays on req 0 until s_busy=0, then switches to req 1 next cycle.
REQ-038 nRST asserted mid-LOCK1 -> state IDLE immediately; req 0 wins next tie.
